// File: rtl/coproc_img_pkg.sv
// Shared constants and types for the coprocessor image bank fill path.
// Row geometry, bank address type and packer state encoding.
package coproc_img_pkg;

    localparam int WORD_W        = 32;
    localparam int ROW_W         = 3072;
    localparam int NUM_ROWS      = 64;
    localparam int WORDS_PER_ROW = ROW_W / WORD_W;
    localparam int ADDR_W        = $clog2(NUM_ROWS);

    typedef logic [ADDR_W-1:0] bank_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } pack_state_e;

endpackage

// File: rtl/img_row_shift_buf.sv
// Row assembly shift register: new words enter at the MSB end.
// Exposes the post-shift value so the bank write can capture a full row.
module img_row_shift_buf
    import coproc_img_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic [WORD_W-1:0] word,
    output logic [ROW_W-1:0]  row_nxt
);

    logic [ROW_W-1:0] row_q;

    assign row_nxt = {word, row_q[ROW_W-1:WORD_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else if (shift_en) begin
            row_q <= row_nxt;
        end
    end

endmodule

// File: rtl/image_row_packer.sv
// Packs 32-bit pixel words into 3072-bit rows and writes 64 rows
// per frame into the coprocessor image bank.
module image_row_packer
    import coproc_img_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [5:0]        bank_waddr,
    output logic              bank_we,
    output logic [ROW_W-1:0]  bank_wdata,
    output logic              busy,
    output logic [6:0]        row_cnt,
    output logic              frame_done
);

    pack_state_e      state;
    pack_state_e      state_nxt;
    logic [6:0]       word_cnt;
    bank_addr_t       row;
    logic [ROW_W-1:0] row_nxt;
    logic             accept;
    logic             last_word;
    logic             last_row;

    assign in_ready  = (state == FILL);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready && !abort;
    assign last_word = (word_cnt == 7'(WORDS_PER_ROW - 1));
    assign last_row  = (row == bank_addr_t'(NUM_ROWS - 1));

    img_row_shift_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .word     (in_data),
        .row_nxt  (row_nxt)
    );

    always_comb begin
        state_nxt = state;
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (start) state_nxt = FILL;
                FILL:  if (accept && last_word) state_nxt = WRITE;
                WRITE: state_nxt = last_row ? DONE : FILL;
                DONE:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bank port is registered on the transition into WRITE so the
    // pulse lands in the cycle right after the last accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt   <= '0;
            row        <= '0;
            row_cnt    <= '0;
            bank_we    <= 1'b0;
            bank_waddr <= '0;
            bank_wdata <= '0;
            frame_done <= 1'b0;
        end else begin
            bank_we    <= 1'b0;
            frame_done <= 1'b0;
            if (state == IDLE && start) begin
                word_cnt <= '0;
                row      <= '0;
                row_cnt  <= '0;
            end
            if (accept) begin
                word_cnt <= last_word ? 7'd0 : word_cnt + 7'd1;
            end
            if (state_nxt == WRITE) begin
                bank_we    <= 1'b1;
                bank_waddr <= row;
                bank_wdata <= row_nxt;
            end
            if (state == WRITE && !abort) begin
                row_cnt <= row_cnt + 7'd1;
                if (!last_row) row <= row + 1'b1;
            end
            if (state_nxt == DONE) begin
                frame_done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/image_row_packer.md
Name: image_row_packer

Overview:
- Upstream fill stage for one 64-row coprocessor image bank.
- Accepts a stream of 32-bit pixel words (4 × 8-bit pixels) over a valid/ready handshake.
- Packs each group of 96 words into one 3072-bit row and issues a single-cycle bank write.
- Advances the row address 0..63, then signals frame completion; the bank write port (waddr/we/wdata) is driven directly from this block.

Parameters:
- WORD_W, 32, input word width in bits
- ROW_W, 3072, bank row width in bits; must be a multiple of WORD_W
- NUM_ROWS, 64, rows per bank; bank address width is clog2(NUM_ROWS) = 6

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin packing a frame; honoured only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE with no further bank writes
- in_data  input  WORD_W  pixel word; byte 0 is the leftmost pixel
- in_valid  input  1  in_data valid
- in_ready  output  1  packer accepts a word this cycle
- bank_waddr  output  6  row address to bank
- bank_we  output  1  bank write enable, one-cycle pulse per row
- bank_wdata  output  ROW_W  packed row to bank
- busy  output  1  high in any state except IDLE
- row_cnt  output  7  rows written in current frame, 0..64
- frame_done  output  1  one-cycle pulse after the 64th row write

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; all outputs 0; row buffer, word counter and row counter cleared.
- Reset mid-frame: no bank_we is produced; a partially filled row is discarded.
- Handshake: a word transfers when in_valid && in_ready. in_ready is combinational from state: 1 only in FILL, with no dependence on in_valid.
- Row buffer: shift register, ROW_W bits. Each accepted word enters at the MSB end; the buffer shifts right by WORD_W. After 96 accepts, word 0 sits at bits [31:0] and word 95 at [3071:3040].
- Word counter: 7 bits, 0..95.
- State IDLE: in_ready=0. start=1 -> FILL; word_cnt=0, row=0, row_cnt=0. in_valid is ignored.
- State FILL: each accept increments word_cnt. Accept with word_cnt==95 -> WRITE, word_cnt wraps to 0.
- State WRITE (exactly one cycle):
  - Registered outputs: bank_we=1, bank_waddr=row, bank_wdata=buffer.
  - in_ready=0.
  - row_cnt increments.
  - If row==63 -> DONE; else row+1 and -> FILL.
- State DONE (one cycle): frame_done=1 -> IDLE.
- bank_we, bank_waddr and bank_wdata are registered. bank_wdata holds its value outside WRITE and is not cleared.
- Latency: last word of a row accepted at cycle N -> bank_we=1 in cycle N+1.
- Throughput: at most one row per 97 cycles.
- start outside IDLE: ignored; no restart.
- abort: highest priority after reset, legal in any non-IDLE state.
  - -> IDLE next cycle.
  - Suppresses bank_we in the same cycle.
  - frame_done is not pulsed; row_cnt holds its value until the next start.
- abort and start in the same cycle in IDLE: start wins. abort has no effect in IDLE.
- Row wrap: row never exceeds 63; a frame is exactly 64 rows. row_cnt reads 64 during DONE and IDLE until the next start.
- in_valid dropping mid-row: FILL waits indefinitely; buffer and counters hold.

Decomposition:
- Package coproc_img_pkg holds:
  - ROW_W, WORD_W, NUM_ROWS
  - WORDS_PER_ROW = ROW_W/WORD_W
  - bank address type logic [5:0]
  - packer state enum {IDLE, FILL, WRITE, DONE}
- One sub-module is natural: img_row_shift_buf.
  - Contents: ROW_W shift register with shift_en and word input, async reset.
  - Counters and FSM stay in image_row_packer.

Test Plan:
- Reset, then start, then 96 words 32'h0000_0000..32'h0000_005F with in_valid continuous -> bank_we high exactly one cycle after the 96th accept; waddr=0; wdata[31:0]=0, wdata[3071:3040]=32'h5F; in_ready=0 during that cycle.
- Full frame of 6144 words, word value = {row[7:0], 16'h0, idx[7:0]} -> 64 bank_we pulses at waddr 0..63 in order; frame_done pulses once, one cycle after the row-63 write; row_cnt=64; busy=0 afterwards.
- in_valid toggled 1/0 every cycle through row 0 -> write occurs only after 96 real accepts; wdata identical to the continuous-valid case.
- abort asserted after 50 words of row 3 -> no bank_we for row 3; IDLE next cycle; frame_done=0. A new start restarts at waddr=0.
- Assert rst_n=0 in the WRITE cycle of row 10 -> bank_we=0 immediately and all outputs 0. After release, start plus 96 words writes waddr=0.
- start pulsed during FILL of row 5 -> ignored; row 5 still written at waddr=5, frame completes normally.
